// File: rtl/d16_pkg.sv
// Shared definitions for the d16 stack cache and the core decoder.
package d16_pkg;

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_PUSH    = 3'b001;
  localparam logic [2:0] OP_POP     = 3'b010;
  localparam logic [2:0] OP_REPLACE = 3'b011;
  localparam logic [2:0] OP_POP2    = 3'b100;
  localparam logic [2:0] OP_SWAP    = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SPILL = 2'd1,
    ST_FILL  = 2'd2
  } state_t;

endpackage

// File: rtl/d16_stack_ram.sv
// On-chip stack storage: DEPTH x WIDTH registers, two write ports so SWAP
// completes in one edge, three combinational read ports (TOS, NOS, bottom).
// Contents are deliberately not reset; cnt in the controller defines validity.
module d16_stack_ram
  import d16_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             wr0_en,
  input  logic [AW-1:0]    wr0_idx,
  input  logic [WIDTH-1:0] wr0_dat,
  input  logic             wr1_en,
  input  logic [AW-1:0]    wr1_idx,
  input  logic [WIDTH-1:0] wr1_dat,
  input  logic [AW-1:0]    tos_idx,
  output logic [WIDTH-1:0] tos_dat,
  input  logic [AW-1:0]    nos_idx,
  output logic [WIDTH-1:0] nos_dat,
  input  logic [AW-1:0]    bot_idx,
  output logic [WIDTH-1:0] bot_dat
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Register array writes; port 1 is applied last if both ever hit one slot.
  always_ff @(posedge i_clk) begin
    if (wr0_en) mem[wr0_idx] <= wr0_dat;
    if (wr1_en) mem[wr1_idx] <= wr1_dat;
  end

  assign tos_dat = mem[tos_idx];
  assign nos_dat = mem[nos_idx];
  assign bot_dat = mem[bot_idx];

endmodule

// File: rtl/d16_stack_cache.sv
// Memory-backed hardware stack: keeps the top DEPTH entries on-chip and
// spills/fills the oldest ones to a Wishbone memory region.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | accepting ops; on-chip buffer neither full nor starved
// ST_SPILL | writing bottom on-chip entry to BASE+mem_cnt, waiting ack
// ST_FILL  | reading BASE+mem_cnt-1 into slot below bottom, waiting ack
//
// The next state is decided from the post-update counters, so the edge that
// accepts a filling PUSH (or draining POP) already enters SPILL (or FILL).
module d16_stack_cache
  import d16_pkg::*;
#(
  parameter  int              WIDTH     = 16,
  parameter  int              DEPTH     = 16,
  parameter  int              MEM_DEPTH = 256,
  parameter  int              ADDR_W    = 16,
  parameter  logic [ADDR_W-1:0] BASE    = ADDR_W'(16'hF000),
  localparam int              DW        = $clog2(DEPTH+MEM_DEPTH+1)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [2:0]        i_op,
  input  logic [WIDTH-1:0]  i_dat,
  output logic [WIDTH-1:0]  o_tos,
  output logic [WIDTH-1:0]  o_nos,
  output logic [DW-1:0]     o_depth,
  output logic              o_err_ovf,
  output logic              o_err_unf,
  input  logic              i_err_clr,
  output logic [ADDR_W-1:0] o_wb_addr,
  output logic [WIDTH-1:0]  o_wb_dat,
  input  logic [WIDTH-1:0]  i_wb_dat,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  input  logic              i_wb_ack
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int MW = $clog2(MEM_DEPTH+1);

  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [MW-1:0] MEM_FULL  = MW'(MEM_DEPTH);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH+MEM_DEPTH);

  state_t            state, state_nx;
  logic [AW-1:0]     top, top_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [MW-1:0]     mem_cnt, mem_nx;
  logic              ovf_set, unf_set;
  logic              spill_need, fill_need, accept;

  logic              wr0_en, wr1_en;
  logic [AW-1:0]     wr0_idx, wr1_idx;
  logic [WIDTH-1:0]  wr0_dat, wr1_dat;
  logic [AW-1:0]     nos_idx, bot_idx, fill_idx;
  logic [WIDTH-1:0]  tos_dat, nos_dat, bot_dat;

  // Live entries occupy slots top, top-1, ..., top-cnt+1 (mod DEPTH).
  assign nos_idx  = top - AW'(1);
  assign bot_idx  = top - AW'(cnt) + AW'(1);
  assign fill_idx = top - AW'(cnt);

  assign o_depth    = DW'(cnt) + DW'(mem_cnt);
  assign spill_need = (cnt == CNT_FULL) && (mem_cnt < MEM_FULL);
  assign fill_need  = (cnt < CW'(2)) && (mem_cnt != '0);
  assign o_ready    = (state == ST_IDLE) && !spill_need && !fill_need;
  assign accept     = i_valid && o_ready;

  assign o_tos = (cnt != '0)      ? tos_dat : '0;
  assign o_nos = (cnt >= CW'(2))  ? nos_dat : '0;

  d16_stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk   (i_clk),
    .wr0_en  (wr0_en),
    .wr0_idx (wr0_idx),
    .wr0_dat (wr0_dat),
    .wr1_en  (wr1_en),
    .wr1_idx (wr1_idx),
    .wr1_dat (wr1_dat),
    .tos_idx (top),
    .tos_dat (tos_dat),
    .nos_idx (nos_idx),
    .nos_dat (nos_dat),
    .bot_idx (bot_idx),
    .bot_dat (bot_dat)
  );

  // Op decode, transfer completion and next-state selection.
  always_comb begin
    top_nx  = top;
    cnt_nx  = cnt;
    mem_nx  = mem_cnt;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    wr0_en  = 1'b0;
    wr0_idx = top;
    wr0_dat = i_dat;
    wr1_en  = 1'b0;
    wr1_idx = nos_idx;
    wr1_dat = tos_dat;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (i_op)
            OP_PUSH: begin
              if (o_depth == DEPTH_MAX) begin
                ovf_set = 1'b1;
              end else begin
                top_nx  = top + AW'(1);
                cnt_nx  = cnt + CW'(1);
                wr0_en  = 1'b1;
                wr0_idx = top + AW'(1);
              end
            end
            OP_POP: begin
              if (o_depth == '0) unf_set = 1'b1;
              else begin
                top_nx = top - AW'(1);
                cnt_nx = cnt - CW'(1);
              end
            end
            OP_REPLACE: begin
              if (o_depth == '0) unf_set = 1'b1;
              else               wr0_en  = 1'b1;
            end
            OP_POP2: begin
              if (o_depth < DW'(2)) unf_set = 1'b1;
              else begin
                top_nx = top - AW'(2);
                cnt_nx = cnt - CW'(2);
              end
            end
            OP_SWAP: begin
              if (o_depth < DW'(2)) unf_set = 1'b1;
              else begin
                wr0_en  = 1'b1;
                wr0_dat = nos_dat;
                wr1_en  = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      ST_SPILL: begin
        if (i_wb_ack) begin
          cnt_nx = cnt - CW'(1);
          mem_nx = mem_cnt + MW'(1);
        end
      end
      ST_FILL: begin
        if (i_wb_ack) begin
          wr0_en  = 1'b1;
          wr0_idx = fill_idx;
          wr0_dat = i_wb_dat;
          cnt_nx  = cnt + CW'(1);
          mem_nx  = mem_cnt - MW'(1);
        end
      end
      default: ;
    endcase

    if ((cnt_nx == CNT_FULL) && (mem_nx < MEM_FULL))
      state_nx = ST_SPILL;
    else if ((cnt_nx < CW'(2)) && (mem_nx != '0))
      state_nx = ST_FILL;
    else
      state_nx = ST_IDLE;
  end

  // FSM, stack pointers, sticky flags and registered Wishbone outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= ST_IDLE;
      top       <= '0;
      cnt       <= '0;
      mem_cnt   <= '0;
      o_err_ovf <= 1'b0;
      o_err_unf <= 1'b0;
      o_wb_cyc  <= 1'b0;
      o_wb_stb  <= 1'b0;
      o_wb_we   <= 1'b0;
      o_wb_addr <= '0;
      o_wb_dat  <= '0;
    end else begin
      state     <= state_nx;
      top       <= top_nx;
      cnt       <= cnt_nx;
      mem_cnt   <= mem_nx;
      o_err_ovf <= ovf_set | (o_err_ovf & ~i_err_clr);
      o_err_unf <= unf_set | (o_err_unf & ~i_err_clr);
      o_wb_cyc  <= (state_nx != ST_IDLE);
      o_wb_stb  <= (state_nx != ST_IDLE);
      o_wb_we   <= (state_nx == ST_SPILL);
      // Entering SPILL from a PUSH, the current bottom slot equals the
      // post-push bottom slot, so bot_dat is already the word to write.
      if (state_nx == ST_SPILL) begin
        o_wb_addr <= BASE + ADDR_W'(mem_nx);
        o_wb_dat  <= bot_dat;
      end else if (state_nx == ST_FILL) begin
        o_wb_addr <= BASE + ADDR_W'(mem_nx) - ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_d16_stack_cache.sv
// Bench for d16_stack_cache (DEPTH=4, MEM_DEPTH=4, BASE=0x0100) with a
// queue-based stack model and a Wishbone slave with programmable ack delay.
module tb_d16_stack_cache;
  import d16_pkg::*;

  localparam int          WIDTH     = 16;
  localparam int          DEPTH     = 4;
  localparam int          MEM_DEPTH = 4;
  localparam int          ADDR_W    = 16;
  localparam logic [15:0] BASE      = 16'h0100;
  localparam int          DW        = $clog2(DEPTH+MEM_DEPTH+1);
  localparam int          MAXD      = DEPTH + MEM_DEPTH;

  logic              clk = 1'b0;
  logic              i_reset_n, i_valid, i_err_clr;
  logic [2:0]        i_op;
  logic [WIDTH-1:0]  i_dat, i_wb_dat;
  logic              o_ready, o_err_ovf, o_err_unf;
  logic [WIDTH-1:0]  o_tos, o_nos, o_wb_dat;
  logic [DW-1:0]     o_depth;
  logic [ADDR_W-1:0] o_wb_addr;
  logic              o_wb_cyc, o_wb_stb, o_wb_we, i_wb_ack;
  logic              ack_r = 1'b0, stray_ack = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mq[$];
  logic        m_ovf, m_unf;

  logic [15:0] smem [16];
  logic [15:0] wr_addr_q[$], wr_dat_q[$], rd_addr_q[$];
  int          ack_delay = 0;
  bit          hold_ack  = 1'b0;

  always #5 clk = ~clk;
  assign i_wb_ack = ack_r | stray_ack;

  d16_stack_cache #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W), .BASE(BASE)
  ) dut (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_dat(i_dat), .o_tos(o_tos), .o_nos(o_nos), .o_depth(o_depth),
    .o_err_ovf(o_err_ovf), .o_err_unf(o_err_unf), .i_err_clr(i_err_clr),
    .o_wb_addr(o_wb_addr), .o_wb_dat(o_wb_dat), .i_wb_dat(i_wb_dat),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .i_wb_ack(i_wb_ack)
  );

  // Wishbone slave: acks after ack_delay wait cycles, one-cycle ack pulse.
  initial begin
    int wcnt;
    int idx;
    wcnt = 0;
    i_wb_dat = '0;
    for (int i = 0; i < 16; i++) smem[i] = 16'hDEAD;
    forever begin
      @(negedge clk);
      if (ack_r) begin
        ack_r = 1'b0;
        wcnt  = 0;
      end
      if (o_wb_cyc && o_wb_stb && !hold_ack) begin
        if (wcnt >= ack_delay) begin
          ack_r = 1'b1;
          idx   = int'(o_wb_addr) - int'(BASE);
          if (o_wb_we) begin
            wr_addr_q.push_back(o_wb_addr);
            wr_dat_q.push_back(o_wb_dat);
            if (idx >= 0 && idx < 16) smem[idx] = o_wb_dat;
          end else begin
            rd_addr_q.push_back(o_wb_addr);
            i_wb_dat = (idx >= 0 && idx < 16) ? smem[idx] : 16'hDEAD;
          end
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  function automatic logic [15:0] m_tos();
    return (mq.size() > 0) ? mq[mq.size()-1] : 16'h0;
  endfunction

  function automatic logic [15:0] m_nos();
    return (mq.size() > 1) ? mq[mq.size()-2] : 16'h0;
  endfunction

  task automatic do_reset();
    i_valid   = 1'b0;
    i_op      = 3'd0;
    i_dat     = '0;
    i_err_clr = 1'b0;
    i_reset_n = 1'b0;
    repeat (3) @(negedge clk);
    i_reset_n = 1'b1;
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    wr_addr_q.delete();
    wr_dat_q.delete();
    rd_addr_q.delete();
  endtask

  task automatic wait_ready(output int n);
    @(negedge clk);
    n = 0;
    while (!o_ready && n < 64) begin
      n++;
      @(negedge clk);
    end
    if (!o_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: o_ready still %0b after %0d cycles, required 1", o_ready, n);
    end
  endtask

  // Issue one accepted op and advance the model by the stack rules.
  task automatic issue_op(input logic [2:0] op, input logic [15:0] dat, input bit clr);
    int n;
    bit so, su;
    int sz;
    logic [15:0] t;
    wait_ready(n);
    i_valid   = 1'b1;
    i_op      = op;
    i_dat     = dat;
    i_err_clr = clr;
    @(posedge clk);
    #1;
    i_valid   = 1'b0;
    i_err_clr = 1'b0;
    so = 1'b0;
    su = 1'b0;
    sz = mq.size();
    case (op)
      3'd1: if (sz == MAXD) so = 1'b1; else mq.push_back(dat);
      3'd2: if (sz == 0) su = 1'b1; else void'(mq.pop_back());
      3'd3: if (sz == 0) su = 1'b1; else mq[sz-1] = dat;
      3'd4: if (sz < 2) su = 1'b1; else begin void'(mq.pop_back()); void'(mq.pop_back()); end
      3'd5: if (sz < 2) su = 1'b1;
            else begin t = mq[sz-1]; mq[sz-1] = mq[sz-2]; mq[sz-2] = t; end
      default: ;
    endcase
    m_ovf = so | (m_ovf & ~clr);
    m_unf = su | (m_unf & ~clr);
  endtask

  task automatic test_reset();
    logic [DW+2*WIDTH+6-1:0] got, want;
    do_reset();
    got  = {o_depth, o_tos, o_nos, o_ready, o_wb_cyc, o_wb_stb, o_wb_we, o_err_ovf, o_err_unf};
    want = {DW'(0), 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h required %h", got, want);
    end
    n_cmp++;
    if ({o_wb_addr, o_wb_dat} !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_wb_bus: got addr %h dat %h required 0/0", o_wb_addr, o_wb_dat);
    end
  endtask

  task automatic test_spill();
    int n;
    do_reset();
    ack_delay = 0;
    for (int v = 1; v <= 4; v++) issue_op(OP_PUSH, 16'(v), 1'b0);
    wait_ready(n);
    n_cmp++;
    if (n != 1) begin n_bad++; $display("FAIL spill_ready_low: got %0d cycles required 1", n); end
    n_cmp++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 16'h0100 || wr_dat_q[0] !== 16'h0001) begin
      n_bad++;
      $display("FAIL spill_write: got %0d writes first %h<=%h required 1 write 0100<=0001",
               wr_addr_q.size(), (wr_addr_q.size() > 0) ? wr_addr_q[0] : 16'hx,
               (wr_dat_q.size() > 0) ? wr_dat_q[0] : 16'hx);
    end
    n_cmp++;
    if ({o_depth, o_tos, o_nos} !== {DW'(4), 16'd4, 16'd3}) begin
      n_bad++;
      $display("FAIL spill_state: got depth %0d tos %h nos %h required 4/0004/0003", o_depth, o_tos, o_nos);
    end
  endtask

  task automatic test_fill();
    int n;
    ack_delay = 2;
    issue_op(OP_POP, 16'h0, 1'b0);
    issue_op(OP_POP, 16'h0, 1'b0);
    wait_ready(n);
    n_cmp++;
    if (n != 3) begin n_bad++; $display("FAIL fill_ready_low: got %0d cycles required 3", n); end
    n_cmp++;
    if (rd_addr_q.size() != 1 || rd_addr_q[0] !== 16'h0100) begin
      n_bad++;
      $display("FAIL fill_read: got %0d reads first %h required 1 read at 0100",
               rd_addr_q.size(), (rd_addr_q.size() > 0) ? rd_addr_q[0] : 16'hx);
    end
    n_cmp++;
    if ({o_depth, o_tos, o_nos} !== {DW'(2), 16'd2, 16'd1}) begin
      n_bad++;
      $display("FAIL fill_state: got depth %0d tos %h nos %h required 2/0002/0001", o_depth, o_tos, o_nos);
    end
    issue_op(OP_POP, 16'h0, 1'b0);
    wait_ready(n);
    n_cmp++;
    if ({o_depth, o_tos} !== {DW'(1), 16'd1}) begin
      n_bad++;
      $display("FAIL fill_last_pop: got depth %0d tos %h required 1/0001", o_depth, o_tos);
    end
  endtask

  task automatic test_overflow();
    int n;
    do_reset();
    ack_delay = 0;
    for (int v = 1; v <= 9; v++) issue_op(OP_PUSH, 16'(v), 1'b0);
    wait_ready(n);
    n_cmp++;
    if ({o_err_ovf, o_depth, o_tos, o_nos} !== {1'b1, DW'(8), 16'd8, 16'd7}) begin
      n_bad++;
      $display("FAIL ovf_state: got ovf %0b depth %0d tos %h nos %h required 1/8/0008/0007",
               o_err_ovf, o_depth, o_tos, o_nos);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (smem[i] !== 16'(i + 1)) begin
        n_bad++;
        $display("FAIL ovf_spill_slot%0d: got %h required %h", i, smem[i], 16'(i + 1));
      end
    end
    issue_op(OP_PUSH, 16'h00AA, 1'b1);
    n_cmp++;
    if (o_err_ovf !== 1'b1 || o_depth !== DW'(8)) begin
      n_bad++;
      $display("FAIL ovf_set_wins: got ovf %0b depth %0d required 1/8", o_err_ovf, o_depth);
    end
    issue_op(OP_NOP, 16'h0, 1'b1);
    n_cmp++;
    if (o_err_ovf !== 1'b0 || o_depth !== DW'(8)) begin
      n_bad++;
      $display("FAIL ovf_clear: got ovf %0b depth %0d required 0/8", o_err_ovf, o_depth);
    end
  endtask

  task automatic test_underflow_swap();
    do_reset();
    ack_delay = 1;
    issue_op(OP_REPLACE, 16'h7777, 1'b0);
    n_cmp++;
    if (o_err_unf !== 1'b1 || o_depth !== DW'(0) || o_tos !== 16'h0) begin
      n_bad++;
      $display("FAIL unf_replace_empty: got unf %0b depth %0d tos %h required 1/0/0000", o_err_unf, o_depth, o_tos);
    end
    issue_op(OP_PUSH, 16'h1234, 1'b1);
    issue_op(OP_POP2, 16'h0, 1'b0);
    n_cmp++;
    if ({o_err_unf, o_depth, o_tos} !== {1'b1, DW'(1), 16'h1234}) begin
      n_bad++;
      $display("FAIL unf_pop2: got unf %0b depth %0d tos %h required 1/1/1234", o_err_unf, o_depth, o_tos);
    end
    issue_op(OP_PUSH, 16'hAAAA, 1'b1);
    issue_op(OP_PUSH, 16'h5555, 1'b0);
    issue_op(OP_SWAP, 16'h0, 1'b0);
    n_cmp++;
    if ({o_err_unf, o_depth, o_tos, o_nos} !== {1'b0, DW'(3), 16'hAAAA, 16'h5555}) begin
      n_bad++;
      $display("FAIL swap: got unf %0b depth %0d tos %h nos %h required 0/3/AAAA/5555",
               o_err_unf, o_depth, o_tos, o_nos);
    end
  endtask

  task automatic test_random();
    int n, r, k;
    logic [2:0] op;
    logic [15:0] a, d;
    do_reset();
    for (int it = 0; it < 400; it++) begin
      ack_delay = $urandom_range(0, 3);
      r = $urandom_range(0, 11);
      if (r < 5)       op = OP_PUSH;
      else if (r < 7)  op = OP_POP;
      else if (r == 7) op = OP_REPLACE;
      else if (r == 8) op = OP_POP2;
      else if (r == 9) op = OP_SWAP;
      else if (r == 10) op = 3'($urandom_range(6, 7));
      else             op = OP_NOP;
      issue_op(op, 16'($urandom), ($urandom_range(0, 7) == 0));
      wait_ready(n);
      n_cmp++;
      if ({o_depth, o_tos, o_nos} !== {DW'(mq.size()), m_tos(), m_nos()}) begin
        n_bad++;
        $display("FAIL rand_stack it%0d op%0d: got depth %0d tos %h nos %h required %0d/%h/%h",
                 it, op, o_depth, o_tos, o_nos, mq.size(), m_tos(), m_nos());
      end
      n_cmp++;
      if ({o_err_ovf, o_err_unf} !== {m_ovf, m_unf}) begin
        n_bad++;
        $display("FAIL rand_flags it%0d: got ovf %0b unf %0b required %0b/%0b", it, o_err_ovf, o_err_unf, m_ovf, m_unf);
      end
      while (wr_addr_q.size() > 0) begin
        a = wr_addr_q.pop_front();
        d = wr_dat_q.pop_front();
        k = int'(a) - int'(BASE);
        n_cmp++;
        if (k < 0 || k >= MEM_DEPTH || k >= mq.size() || d !== mq[k]) begin
          n_bad++;
          $display("FAIL rand_spill_write it%0d: got %h<=%h required entry %0d of the stack", it, a, d, k);
        end
      end
      while (rd_addr_q.size() > 0) begin
        a = rd_addr_q.pop_front();
        k = int'(a) - int'(BASE);
        n_cmp++;
        if (k < 0 || k >= MEM_DEPTH || k >= mq.size()) begin
          n_bad++;
          $display("FAIL rand_fill_read it%0d: got read at %h required index below depth %0d", it, a, mq.size());
        end
      end
    end
  endtask

  task automatic test_reset_mid_spill();
    do_reset();
    hold_ack = 1'b1;
    for (int v = 1; v <= 4; v++) issue_op(OP_PUSH, 16'(v + 16'h40), 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({o_wb_cyc, o_wb_stb, o_wb_we, o_ready} !== 4'b1110) begin
      n_bad++;
      $display("FAIL midspill_busy: got cyc/stb/we/ready %b required 1110", {o_wb_cyc, o_wb_stb, o_wb_we, o_ready});
    end
    #2 i_reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_wb_cyc, o_wb_stb, o_wb_we} !== 3'b000 || o_depth !== DW'(0) || o_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midspill_async: got cyc/stb/we %b depth %0d ready %0b required 000/0/1",
               {o_wb_cyc, o_wb_stb, o_wb_we}, o_depth, o_ready);
    end
    @(negedge clk);
    i_reset_n = 1'b1;
    hold_ack  = 1'b0;
    mq.delete();
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({o_wb_cyc, o_ready, o_depth, o_tos} !== {1'b0, 1'b1, DW'(0), 16'h0}) begin
      n_bad++;
      $display("FAIL midspill_late_ack: got cyc %0b ready %0b depth %0d tos %h required 0/1/0/0000",
               o_wb_cyc, o_ready, o_depth, o_tos);
    end
  endtask

  initial begin
    test_reset();
    test_spill();
    test_fill();
    test_overflow();
    test_underflow_swap();
    test_random();
    test_reset_mid_spill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
